mem_dump_reader: RTL

Post-run memory readback engine for the pipelined core. It walks a block of word-aligned memory through a 1-cycle-latency read port and streams each word with its byte address over a valid/ready interface. This lets the bench or a host link dump data or instruction memory after a program halts. It is the read-side counterpart of the `we0`/`wr_addr0`/`wr_din0` load path and uses the same byte-address scheme: word *i* is at address 4·*i*.

---
 rtl/riscv_mem_pkg.sv | 18 +
 rtl/dump_fifo2.sv | 57 +++++
 rtl/mem_dump_reader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared memory-side definitions for the core's load and readback paths.
//   WORD_BYTES   : byte stride between consecutive memory words
//   *_W_DEF      : default widths matching the we0/wr_addr0/wr_din0 load port
//   dump_state_t : readback engine FSM states
package riscv_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } dump_state_t;

endpackage

// File: rtl/dump_fifo2.sv
// Two-entry FIFO of {addr, data} pairs feeding the dump output stream.
//   clk, reset          : clock, synchronous active-high reset
//   push, push_addr/data : write one pair
//   pop                 : drop the head pair (caller only pops when valid)
//   count               : current occupancy (0..2)
//   head_valid/addr/data : oldest stored pair
module dump_fifo2 #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
);

    logic [ADDR_W-1:0] addr_q [2];
    logic [DATA_W-1:0] data_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    // Storage and pointers; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q[0] <= '0;
            addr_q[1] <= '0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= push_addr;
                data_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head_addr  = addr_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];

endmodule

// File: rtl/mem_dump_reader.sv
// Post-run memory readback engine: walks word_count words from base_addr
// through a 1-cycle-latency read port and streams {addr, data} beats.
//   clk, reset               : clock, synchronous active-high reset
//   start, base_addr, word_count : dump request, sampled only in IDLE
//   busy, done               : engine active / one-cycle completion pulse
//   rd_en, rd_addr, rd_data  : memory read port (data one cycle after rd_en)
//   out_valid/ready/data/addr/last : output stream
module mem_dump_reader
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  issue_left_q, issue_left_d;
    logic [CNT_W-1:0]  pop_left_q, pop_left_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] req_addr_q;

    logic [1:0]        fifo_count;
    logic              pop;
    logic [2:0]        credit_used;

    assign pop = out_valid && out_ready;

    // Slots committed after this cycle; a same-cycle pop frees its slot.
    assign credit_used = 3'(inflight_q) + 3'(fifo_count) - 3'(pop);

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            pop_left_q   <= '0;
            inflight_q   <= 1'b0;
            req_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            inflight_q   <= rd_en;
            if (rd_en) begin
                req_addr_q <= addr_q;
            end
        end
    end

    // Next-state, read issue and counter updates.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q;
        rd_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    addr_d       = {base_addr[ADDR_W-1:2], 2'b00};
                    issue_left_d = word_count;
                    pop_left_d   = word_count;
                end
            end
            ST_RUN: begin
                if ((issue_left_q != '0) && (credit_used < 3'd2)) begin
                    rd_en        = 1'b1;
                    addr_d       = addr_q + ADDR_W'(WORD_BYTES);
                    issue_left_d = issue_left_q - CNT_W'(1);
                end
                if (pop) begin
                    pop_left_d = pop_left_q - CNT_W'(1);
                end
                if ((issue_left_q == '0) &&
                    ((pop_left_q == '0) || ((pop_left_q == CNT_W'(1)) && pop))) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Returned read data is captured the cycle after issue, tagged with its address.
    dump_fifo2 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (inflight_q),
        .push_addr  (req_addr_q),
        .push_data  (rd_data),
        .pop        (pop),
        .count      (fifo_count),
        .head_valid (out_valid),
        .head_addr  (out_addr),
        .head_data  (out_data)
    );

    assign rd_addr  = addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FINISH);
    assign out_last = out_valid && (pop_left_q == CNT_W'(1));

endmodule
